// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32i datapath: RAW stall, jump/branch redirect,
// in-flight destination scoreboard (E, M, W) and stall/flush performance counters.
module rv32i_hazard_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned STALL_ON_WB = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       dec_rs1_add_i,
    input  logic [4:0]       dec_rs2_add_i,
    input  logic [4:0]       dec_rd_add_i,
    input  logic             dec_uses_rs1_i,
    input  logic             dec_uses_rs2_i,
    input  logic             dec_writes_rd_i,
    input  logic             dec_is_jal_i,
    input  logic             dec_is_jalr_i,
    input  logic             dec_is_branch_i,
    input  logic             exec_br_cond_i,
    output logic             stall_o,
    output logic             fetch_nop_o,
    output logic             dec_nop_o,
    output logic [2:0]       pc_next_sel_o,
    output logic [4:0]       wb_rd_add_o,
    output logic             wb_reg_we_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [2:0] {
        SEL_PC_PLUS_4 = 3'd0,
        SEL_PC_BRANCH = 3'd1,
        SEL_PC_JAL    = 3'd2,
        SEL_PC_JALR   = 3'd3
    } pc_sel_e;

    localparam logic WB_CMP = (STALL_ON_WB != 0);

    logic             d_valid_q, d_valid_d;
    logic             e_v_q, e_v_d;
    logic [4:0]       e_rd_q, e_rd_d;
    logic             e_br_q, e_br_d;
    logic             m_v_q, m_v_d;
    logic [4:0]       m_rd_q, m_rd_d;
    logic             w_v_q, w_v_d;
    logic [4:0]       w_rd_q, w_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic    rs1_hit, rs2_hit;
    logic    taken, raw, jump;
    logic    stall, fetch_nop, dec_nop;
    pc_sel_e pc_sel;

    assign rs1_hit = (e_v_q && (e_rd_q == dec_rs1_add_i))
                   || (m_v_q && (m_rd_q == dec_rs1_add_i))
                   || (WB_CMP && w_v_q && (w_rd_q == dec_rs1_add_i));
    assign rs2_hit = (e_v_q && (e_rd_q == dec_rs2_add_i))
                   || (m_v_q && (m_rd_q == dec_rs2_add_i))
                   || (WB_CMP && w_v_q && (w_rd_q == dec_rs2_add_i));

    assign taken = e_br_q && exec_br_cond_i;
    assign raw   = d_valid_q && ((dec_uses_rs1_i && rs1_hit) || (dec_uses_rs2_i && rs2_hit));
    assign jump  = d_valid_q && (dec_is_jal_i || dec_is_jalr_i);

    // A taken branch kills the D instruction, so its raw/jump terms are ignored.
    always_comb begin
        stall     = 1'b0;
        fetch_nop = 1'b0;
        dec_nop   = !d_valid_q;
        pc_sel    = SEL_PC_PLUS_4;
        if (taken) begin
            pc_sel    = SEL_PC_BRANCH;
            fetch_nop = 1'b1;
            dec_nop   = 1'b1;
        end else if (raw) begin
            stall     = 1'b1;
            dec_nop   = 1'b1;
        end else if (jump) begin
            pc_sel    = dec_is_jal_i ? SEL_PC_JAL : SEL_PC_JALR;
            fetch_nop = 1'b1;
            dec_nop   = 1'b0;
        end
    end

    always_comb begin
        w_v_d       = m_v_q;
        w_rd_d      = m_rd_q;
        m_v_d       = e_v_q;
        m_rd_d      = e_rd_q;
        e_v_d       = 1'b0;
        e_rd_d      = '0;
        e_br_d      = 1'b0;
        d_valid_d   = d_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!dec_nop) begin
            e_v_d  = dec_writes_rd_i && (dec_rd_add_i != 5'd0);
            e_rd_d = dec_rd_add_i;
            e_br_d = dec_is_branch_i;
        end
        if (!stall) begin
            d_valid_d = !fetch_nop;
        end
        if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (fetch_nop) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            d_valid_q   <= 1'b0;
            e_v_q       <= 1'b0;
            e_rd_q      <= '0;
            e_br_q      <= 1'b0;
            m_v_q       <= 1'b0;
            m_rd_q      <= '0;
            w_v_q       <= 1'b0;
            w_rd_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            d_valid_q   <= d_valid_d;
            e_v_q       <= e_v_d;
            e_rd_q      <= e_rd_d;
            e_br_q      <= e_br_d;
            m_v_q       <= m_v_d;
            m_rd_q      <= m_rd_d;
            w_v_q       <= w_v_d;
            w_rd_q      <= w_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o       = stall;
    assign fetch_nop_o   = fetch_nop;
    assign dec_nop_o     = dec_nop;
    assign pc_next_sel_o = pc_sel;
    assign wb_rd_add_o   = w_rd_q;
    assign wb_reg_we_o   = w_v_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Bench for rv32i_hazard_ctrl: three configurations driven in lockstep, a directed vector
// table, a history-based reference model under random stimulus, and counter wrap/reset sequences.
module tb_rv32i_hazard_ctrl;

    localparam logic [2:0] P4 = 3'd0;
    localparam logic [2:0] PB = 3'd1;
    localparam logic [2:0] PJ = 3'd2;
    localparam logic [2:0] PR = 3'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, jal, jalr, br, cond;

    logic [2:0]      o_st, o_fn, o_dn, o_we;
    logic [2:0][2:0] o_sel;
    logic [2:0][4:0] o_wrd;
    logic [31:0]     o_sc0, o_sc1, o_fc0, o_fc1;
    logic [3:0]      o_sc2, o_fc2;

    rv32i_hazard_ctrl #(.CNT_W(32), .STALL_ON_WB(1)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .dec_rs1_add_i(rs1), .dec_rs2_add_i(rs2), .dec_rd_add_i(rd),
        .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2), .dec_writes_rd_i(wr),
        .dec_is_jal_i(jal), .dec_is_jalr_i(jalr), .dec_is_branch_i(br),
        .exec_br_cond_i(cond),
        .stall_o(o_st[0]), .fetch_nop_o(o_fn[0]), .dec_nop_o(o_dn[0]),
        .pc_next_sel_o(o_sel[0]), .wb_rd_add_o(o_wrd[0]), .wb_reg_we_o(o_we[0]),
        .stall_cnt_o(o_sc0), .flush_cnt_o(o_fc0)
    );

    rv32i_hazard_ctrl #(.CNT_W(32), .STALL_ON_WB(0)) u_dut_nw (
        .clk_i(clk), .reset_i(reset),
        .dec_rs1_add_i(rs1), .dec_rs2_add_i(rs2), .dec_rd_add_i(rd),
        .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2), .dec_writes_rd_i(wr),
        .dec_is_jal_i(jal), .dec_is_jalr_i(jalr), .dec_is_branch_i(br),
        .exec_br_cond_i(cond),
        .stall_o(o_st[1]), .fetch_nop_o(o_fn[1]), .dec_nop_o(o_dn[1]),
        .pc_next_sel_o(o_sel[1]), .wb_rd_add_o(o_wrd[1]), .wb_reg_we_o(o_we[1]),
        .stall_cnt_o(o_sc1), .flush_cnt_o(o_fc1)
    );

    rv32i_hazard_ctrl #(.CNT_W(4), .STALL_ON_WB(1)) u_dut_c4 (
        .clk_i(clk), .reset_i(reset),
        .dec_rs1_add_i(rs1), .dec_rs2_add_i(rs2), .dec_rd_add_i(rd),
        .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2), .dec_writes_rd_i(wr),
        .dec_is_jal_i(jal), .dec_is_jalr_i(jalr), .dec_is_branch_i(br),
        .exec_br_cond_i(cond),
        .stall_o(o_st[2]), .fetch_nop_o(o_fn[2]), .dec_nop_o(o_dn[2]),
        .pc_next_sel_o(o_sel[2]), .wb_rd_add_o(o_wrd[2]), .wb_reg_we_o(o_we[2]),
        .stall_cnt_o(o_sc2), .flush_cnt_o(o_fc2)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: issued[k][0] is the newest instruction sent to E, [1] the one before, [2] before that.
    typedef struct packed {
        logic       writes;
        logic [4:0] rd;
        logic       is_br;
    } iss_t;

    iss_t        issued [3][3];
    bit          m_dv   [3];
    int unsigned m_sc   [3];
    int unsigned m_fc   [3];
    bit          model_ok = 1'b0;

    function automatic bit pending_write(input int k, input logic [4:0] rs);
        int unsigned depth;
        depth = (k == 1) ? 2 : 3;
        for (int unsigned a = 0; a < depth; a++)
            if (issued[k][a].writes && issued[k][a].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_outputs(input int k, output bit st, output bit fn, output bit dn,
                             output logic [2:0] sel);
        bit tk, hz, jp;
        tk = issued[k][0].is_br && cond;
        hz = m_dv[k] && ((u1 && pending_write(k, rs1)) || (u2 && pending_write(k, rs2)));
        jp = m_dv[k] && (jal || jalr);
        st = 1'b0; fn = 1'b0; dn = !m_dv[k]; sel = P4;
        if (tk) begin
            sel = PB; fn = 1'b1; dn = 1'b1;
        end else if (hz) begin
            st = 1'b1; dn = 1'b1;
        end else if (jp) begin
            sel = jal ? PJ : PR; fn = 1'b1; dn = 1'b0;
        end
    endtask

    function automatic logic [31:0] act_sc(input int k);
        return (k == 0) ? o_sc0 : (k == 1) ? o_sc1 : {28'd0, o_sc2};
    endfunction

    function automatic logic [31:0] act_fc(input int k);
        return (k == 0) ? o_fc0 : (k == 1) ? o_fc1 : {28'd0, o_fc2};
    endfunction

    // One clock: compare all instances against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit st, fn, dn;
        logic [2:0] sel;
        logic [31:0] msk;
        @(negedge clk);
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                m_outputs(k, st, fn, dn, sel);
                msk = (k == 2) ? 32'hF : 32'hFFFF_FFFF;
                chk($sformatf("model stall[%0d]", k), 32'(o_st[k]), 32'(st));
                chk($sformatf("model fetch_nop[%0d]", k), 32'(o_fn[k]), 32'(fn));
                chk($sformatf("model dec_nop[%0d]", k), 32'(o_dn[k]), 32'(dn));
                chk($sformatf("model pc_sel[%0d]", k), 32'(o_sel[k]), 32'(sel));
                chk($sformatf("model wb_we[%0d]", k), 32'(o_we[k]), 32'(issued[k][2].writes));
                chk($sformatf("model wb_rd[%0d]", k), 32'(o_wrd[k]), 32'(issued[k][2].rd));
                chk($sformatf("model stall_cnt[%0d]", k), act_sc(k), m_sc[k] & msk);
                chk($sformatf("model flush_cnt[%0d]", k), act_fc(k), m_fc[k] & msk);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_outputs(k, st, fn, dn, sel);
            if (reset) begin
                for (int a = 0; a < 3; a++) issued[k][a] = '0;
                m_dv[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if (st) m_sc[k]++;
                if (fn) m_fc[k]++;
                issued[k][2] = issued[k][1];
                issued[k][1] = issued[k][0];
                issued[k][0] = dn ? iss_t'('0) : '{wr && (rd != 5'd0), rd, br};
                if (!st) m_dv[k] = !fn;
            end
        end
        if (reset) model_ok = 1'b1;
        #1;
    endtask

    task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                          input logic e1, input logic e2, input logic w, input logic j,
                          input logic jr, input logic b, input logic c);
        rs1 = a1; rs2 = a2; rd = ad; u1 = e1; u2 = e2; wr = w;
        jal = j; jalr = jr; br = b; cond = c;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, w, jal, jalr, br, cond;
        logic st, fn, dn;
        logic [2:0] sel;
        logic we;
        logic [4:0] wrd;
        int unsigned sc, fc;
    } vec_t;

    vec_t tbl [19];

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            rs1 rs2 rd u1 u2 w jal jalr br cond | st fn dn sel we wrd sc fc
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, P4, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 5, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 0, 0};
        tbl[3]  = '{5, 1, 6, 1, 1, 1, 0, 0, 0, 0,  1, 0, 1, P4, 0, 0, 0, 0};
        tbl[4]  = '{5, 1, 6, 1, 1, 1, 0, 0, 0, 0,  1, 0, 1, P4, 0, 0, 1, 0};
        tbl[5]  = '{5, 1, 6, 1, 1, 1, 0, 0, 0, 0,  1, 0, 1, P4, 1, 5, 2, 0};
        tbl[6]  = '{5, 1, 6, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 3, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0,  0, 1, 0, PJ, 0, 0, 3, 0};
        tbl[8]  = '{6, 0, 2, 1, 0, 1, 1, 0, 0, 0,  0, 0, 1, P4, 0, 0, 3, 1};
        tbl[9]  = '{0, 0, 7, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, P4, 1, 6, 3, 1};
        tbl[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0,  0, 0, 0, P4, 1, 1, 3, 1};
        tbl[11] = '{7, 7, 7, 1, 1, 1, 0, 0, 0, 1,  0, 1, 1, PB, 0, 0, 3, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, P4, 1, 7, 3, 2};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 3, 2};
        tbl[14] = '{0, 0, 8, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 3, 2};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 3, 2};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, P4, 0, 0, 3, 2};
        tbl[17] = '{8, 0, 1, 1, 0, 1, 0, 1, 0, 0,  1, 0, 1, P4, 1, 8, 3, 2};
        tbl[18] = '{8, 0, 1, 1, 0, 1, 0, 1, 0, 0,  0, 1, 0, PR, 0, 0, 4, 2};

        #1;
        cycle();
        cycle();
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2, tbl[i].w,
                   tbl[i].jal, tbl[i].jalr, tbl[i].br, tbl[i].cond);
            #3;
            chk($sformatf("vec%0d stall", i), 32'(o_st[0]), 32'(tbl[i].st));
            chk($sformatf("vec%0d fetch_nop", i), 32'(o_fn[0]), 32'(tbl[i].fn));
            chk($sformatf("vec%0d dec_nop", i), 32'(o_dn[0]), 32'(tbl[i].dn));
            chk($sformatf("vec%0d pc_sel", i), 32'(o_sel[0]), 32'(tbl[i].sel));
            chk($sformatf("vec%0d wb_we", i), 32'(o_we[0]), 32'(tbl[i].we));
            chk($sformatf("vec%0d wb_rd", i), 32'(o_wrd[0]), 32'(tbl[i].wrd));
            chk($sformatf("vec%0d stall_cnt", i), o_sc0, tbl[i].sc);
            chk($sformatf("vec%0d flush_cnt", i), o_fc0, tbl[i].fc);
            cycle();
        end

        for (int n = 0; n < 1500; n++) begin
            int unsigned op;
            op = $urandom_range(9);
            reset = ($urandom_range(99) == 0);
            set_in(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   op == 0, op == 1, op == 2, 1'($urandom_range(1)));
            cycle();
        end

        // Counter wrap on the 4-bit instance: five producer/consumer pairs give 15 stalls.
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
        cycle();
        for (int r = 0; r < 5; r++) begin
            set_in(0, 0, 5, 1, 0, 1, 0, 0, 0, 0);
            cycle();
            set_in(5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
            for (int c = 0; c < 4; c++) cycle();
        end
        chk("wrap pre stall_cnt4", {28'd0, o_sc2}, 32'd15);
        chk("wrap pre stall_cnt32", o_sc0, 32'd15);
        chk("wrap pre stall_cnt_nowb", o_sc1, 32'd10);
        set_in(0, 0, 5, 1, 0, 1, 0, 0, 0, 0);
        cycle();
        set_in(5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
        cycle();
        chk("wrap stall_cnt4", {28'd0, o_sc2}, 32'd0);
        chk("wrap stall_cnt32", o_sc0, 32'd16);
        chk("wrap still stalled", 32'(o_st[2]), 32'd1);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst stall[%0d]", k), 32'(o_st[k]), 32'd0);
            chk($sformatf("rst dec_nop[%0d]", k), 32'(o_dn[k]), 32'd1);
            chk($sformatf("rst stall_cnt[%0d]", k), act_sc(k), 32'd0);
            chk($sformatf("rst flush_cnt[%0d]", k), act_fc(k), 32'd0);
            chk($sformatf("rst wb_we[%0d]", k), 32'(o_we[k]), 32'd0);
        end
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
